mem_arbiter: RTL and testbench

Single-port arbiter for the data memory in the MEM stage. Shares the one DataMem access port (addr/wdata/rd/wr/rdata) between the pipeline MEM stage (always-ready, priority owner) and one secondary bus master (UART loader / DMA engine) using a req/ack handshake. DMA accesses steal idle CPU slots; a bounded-wait counter forces a grant and stalls the pipeline for one cycle when the CPU never idles. Sits between MEM and DataMem; `cpu_stall` feeds the hazard unit.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single DataMem access port between the pipeline MEM stage
// (priority owner, never waits unless forced) and one secondary bus master
// (UART loader / DMA engine) on a req/ack handshake.
//
// The DMA master normally takes cycles in which the CPU makes no access.
// If the CPU keeps the port busy, a bounded-wait counter forces a single
// DMA cycle, and the MEM stage is stalled for that one cycle.
//
// Ports
//   clk, reset_b                     clock, async active-low reset
//   cpu_rd/cpu_wr/cpu_addr/cpu_wdata MEM-stage access request
//   cpu_rdata                        load data back to MEM stage
//   cpu_stall                        hold MEM and earlier stages this cycle
//   dma_req/dma_we/dma_addr/dma_wdata DMA request, held until dma_ack
//   dma_ack                          one-cycle pulse: access done this cycle
//   dma_err                          with dma_ack: address rejected
//   dma_rdata                        registered data of the last DMA read
//   mem_rd/mem_wr/mem_addr/mem_wdata to DataMem
//   mem_rdata                        from DataMem (combinational read)
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned MAX_WAIT       = 8,             // >= 1
  parameter logic [31:0] DMA_ADDR_LIMIT = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset_b,
  // MEM stage
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  // secondary master
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic        dma_err,
  output logic [31:0] dma_rdata,
  // DataMem port
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned          WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0]    WAIT_SAT  = WAIT_W'(MAX_WAIT);

  typedef enum logic {
    CPU_OWN = 1'b0,
    DMA_OWN = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
  logic              cpu_idle;
  logic              dma_ok;

  assign cpu_idle  = !cpu_rd && !cpu_wr;
  // Peripheral space is off limits to the DMA master.
  assign dma_ok    = (dma_addr < DMA_ADDR_LIMIT);
  // The MEM stage only consumes this when it is not stalled.
  assign cpu_rdata = mem_rdata;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state     <= CPU_OWN;
      wait_cnt  <= '0;
      dma_rdata <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      // Only an accepted read updates the data register; rejected reads
      // and writes leave the last read value in place.
      if (state == DMA_OWN && !dma_we && dma_ok) begin
        dma_rdata <= mem_rdata;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    mem_rd        = cpu_rd;
    mem_wr        = cpu_wr;
    mem_addr      = cpu_addr;
    mem_wdata     = cpu_wdata;
    cpu_stall     = 1'b0;
    dma_ack       = 1'b0;
    dma_err       = 1'b0;

    case (state)
      CPU_OWN: begin
        if (!dma_req) begin
          wait_cnt_next = '0;
        end else if (cpu_idle || wait_cnt == WAIT_LAST) begin
          // Steal an idle slot, or force the grant once the wait bound
          // is reached.
          state_next    = DMA_OWN;
          wait_cnt_next = '0;
        end else if (wait_cnt != WAIT_SAT) begin
          wait_cnt_next = wait_cnt + WAIT_W'(1);
        end
      end

      DMA_OWN: begin
        // Single cycle, so at least one CPU slot separates DMA grants.
        state_next    = CPU_OWN;
        wait_cnt_next = '0;
        mem_addr      = dma_addr;
        mem_wdata     = dma_wdata;
        mem_wr        = dma_we && dma_ok;
        mem_rd        = !dma_we && dma_ok;
        dma_ack       = 1'b1;
        dma_err       = !dma_ok;
        // The CPU access is held off one cycle and never reaches DataMem.
        cpu_stall     = cpu_rd || cpu_wr;
      end

      default: begin
        state_next = CPU_OWN;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Scoreboard bench for mem_arbiter. A word-addressed DataMem model sits on
// the mem_* port. The stimulus process drives the CPU and DMA sides, and a
// reference model predicts each cycle's outcome from the arbitration rules:
//   - a pending DMA request is served in the cycle after an idle CPU slot,
//     or after it has been refused MAX_WAIT-1 times, whichever comes first;
//   - a DMA cycle is followed by at least one CPU cycle;
//   - addresses at or above the limit are acknowledged with an error and
//     never touch memory.
// Predictions go into queues, and a negedge monitor compares them against
// the DUT. A second instance with MAX_WAIT=1 covers the tightest bound.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int unsigned MAX_WAIT = 8;
  localparam logic [31:0] LIMIT    = 32'h4000_0000;
  localparam logic [31:0] K1       = 32'h5A5A_0000;

  logic clk     = 1'b0;
  logic reset_b = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic        cpu_rd, cpu_wr, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_ack, dma_err;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.MAX_WAIT(MAX_WAIT), .DMA_ADDR_LIMIT(LIMIT)) u_dut (
    .clk(clk), .reset_b(reset_b),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_err(dma_err),
    .dma_rdata(dma_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- MAX_WAIT=1 DUT ----------------
  logic        cpu_rd1, cpu_wr1, cpu_stall1;
  logic [31:0] cpu_addr1, cpu_wdata1, cpu_rdata1;
  logic        dma_req1, dma_we1, dma_ack1, dma_err1;
  logic [31:0] dma_addr1, dma_wdata1, dma_rdata1;
  logic        mem_rd1, mem_wr1;
  logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;

  mem_arbiter #(.MAX_WAIT(1), .DMA_ADDR_LIMIT(LIMIT)) u_dut1 (
    .clk(clk), .reset_b(reset_b),
    .cpu_rd(cpu_rd1), .cpu_wr(cpu_wr1), .cpu_addr(cpu_addr1),
    .cpu_wdata(cpu_wdata1), .cpu_rdata(cpu_rdata1), .cpu_stall(cpu_stall1),
    .dma_req(dma_req1), .dma_we(dma_we1), .dma_addr(dma_addr1),
    .dma_wdata(dma_wdata1), .dma_ack(dma_ack1), .dma_err(dma_err1),
    .dma_rdata(dma_rdata1),
    .mem_rd(mem_rd1), .mem_wr(mem_wr1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  // Address-derived read data is enough for the second instance.
  assign mem_rdata1 = mem_addr1 ^ K1;

  // ---------------- DataMem model + LED register ----------------
  function automatic logic [31:0] init_word(input int i);
    return 32'hA000_0000 + 32'(i) * 32'h0001_0011;
  endfunction

  logic [31:0] dmem [64];
  logic [31:0] led;

  always @(posedge clk) begin
    if (!reset_b) begin
      for (int i = 0; i < 64; i++) dmem[i] <= init_word(i);
      led <= '0;
    end else if (mem_wr) begin
      if (mem_addr >= LIMIT) led <= mem_wdata;
      else                   dmem[mem_addr[5:0]] <= mem_wdata;
    end
  end

  assign mem_rdata = (mem_addr >= LIMIT) ? led : dmem[mem_addr[5:0]];

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic mon_en = 1'b0;

  task automatic check1(input string name, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        ack;
    logic        err;
    logic        stall;
    logic        mrd;
    logic        mwr;
    logic [31:0] maddr;
    logic [31:0] dma_rdata;
  } cyc_exp_t;

  cyc_exp_t    exp_cyc[$];
  logic [31:0] exp_load[$];

  logic [31:0] m_mem [64];
  logic [31:0] m_dma_rdata;
  logic        m_grant;   // this cycle belongs to the DMA master
  int          m_waited;  // cycles the pending request has been refused

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_mem[i] = init_word(i);
    m_dma_rdata = '0;
    m_grant     = 1'b0;
    m_waited    = 0;
  endtask

  // Predicts the outcome of the cycle whose inputs are currently applied.
  task automatic model_step();
    cyc_exp_t e;
    logic     ok;
    e = '0;
    e.dma_rdata = m_dma_rdata;
    if (m_grant) begin
      ok      = (dma_addr < LIMIT);
      e.ack   = 1'b1;
      e.err   = !ok;
      e.stall = cpu_rd || cpu_wr;
      e.mrd   = !dma_we && ok;
      e.mwr   = dma_we && ok;
      e.maddr = dma_addr;
      if (ok && dma_we)  m_mem[dma_addr[5:0]] = dma_wdata;
      if (ok && !dma_we) m_dma_rdata = m_mem[dma_addr[5:0]];
      m_grant  = 1'b0;
      m_waited = 0;
    end else begin
      e.mrd   = cpu_rd;
      e.mwr   = cpu_wr;
      e.maddr = cpu_addr;
      if (cpu_rd) exp_load.push_back(m_mem[cpu_addr[5:0]]);
      if (cpu_wr) m_mem[cpu_addr[5:0]] = cpu_wdata;
      if (!dma_req) begin
        m_waited = 0;
      end else if ((!cpu_rd && !cpu_wr) || (m_waited + 1 >= int'(MAX_WAIT))) begin
        m_grant  = 1'b1;
        m_waited = 0;
      end else begin
        m_waited++;
      end
    end
    exp_cyc.push_back(e);
  endtask

  // ---------------- monitor ----------------
  cyc_exp_t mon_e;

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_cyc.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow: DUT cycle with no prediction (cycle %0d)", cyc);
      end else begin
        mon_e = exp_cyc.pop_front();
        check1("dma_ack", dma_ack, mon_e.ack);
        if (mon_e.ack) check1("dma_err", dma_err, mon_e.err);
        check1("cpu_stall", cpu_stall, mon_e.stall);
        check1("mem_rd", mem_rd, mon_e.mrd);
        check1("mem_wr", mem_wr, mon_e.mwr);
        check32("mem_addr", mem_addr, mon_e.maddr);
        check32("dma_rdata", dma_rdata, mon_e.dma_rdata);
      end
      if (cpu_rd && !cpu_stall) begin
        if (exp_load.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL load_underflow: unexpected completed CPU load (cycle %0d)", cyc);
        end else begin
          check32("cpu_rdata", cpu_rdata, exp_load.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // One clock cycle with the inputs as currently applied.
  task automatic tick(output logic got_ack, output logic got_stall);
    model_step();
    @(negedge clk);
    got_ack   = dma_ack;
    got_stall = cpu_stall;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Issues one DMA access and returns the cycle of its ack (-1 on timeout).
  // cpu_mode 0: CPU idle; 1: CPU loads every cycle (held while stalled).
  // dma_req is left high so consecutive calls model a held request.
  task automatic dma_access(input string name, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int cpu_mode, input int max_cyc,
                            output int ack_cyc);
    logic ga, gs, held;
    held      = 1'b0;
    ack_cyc   = -1;
    dma_req   = 1'b1;
    dma_we    = we;
    dma_addr  = addr;
    dma_wdata = wdata;
    for (int n = 0; n < max_cyc; n++) begin
      if (cpu_mode == 1 && !held) begin
        cpu_rd   = 1'b1;
        cpu_wr   = 1'b0;
        cpu_addr = 32'($urandom_range(0, 63));
      end else if (cpu_mode == 0) begin
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
      end
      tick(ga, gs);
      held = gs;
      if (ga) begin
        ack_cyc = cyc - 1;
        break;
      end
    end
    if (ack_cyc < 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: no dma_ack within %0d cycles", name, max_cyc);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int   n0, a0, a1, a2;
    logic ga, gs, hold_cpu, want;
    logic [31:0] led_before;
    int   r, idle_pct;

    cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    cpu_rd1 = 0; cpu_wr1 = 0; cpu_addr1 = 0; cpu_wdata1 = 0;
    dma_req1 = 0; dma_we1 = 0; dma_addr1 = 0; dma_wdata1 = 0;
    model_reset();

    // Reset state: no DMA activity, mem_* follow the CPU.
    repeat (2) @(posedge clk);
    #1;
    cpu_rd   = 1'b1;
    cpu_addr = 32'h14;
    #1;
    check1("rst_dma_ack", dma_ack, 1'b0);
    check1("rst_dma_err", dma_err, 1'b0);
    check1("rst_cpu_stall", cpu_stall, 1'b0);
    check32("rst_dma_rdata", dma_rdata, 32'h0);
    check1("rst_mem_rd", mem_rd, 1'b1);
    check32("rst_mem_addr", mem_addr, 32'h14);
    cpu_rd  = 1'b0;
    reset_b = 1'b1;
    mon_en  = 1'b1;

    // Idle steal: ack in the next cycle, then the CPU reads the new word.
    n0 = cyc;
    dma_access("idle_steal", 1'b1, 32'h10, 32'h1234_5678, 0, 20, a0);
    check32("idle_steal_latency", 32'(a0 - n0), 32'd1);
    dma_req  = 1'b0;
    cpu_rd   = 1'b1;
    cpu_addr = 32'h10;
    tick(ga, gs);
    cpu_rd = 1'b0;
    tick(ga, gs);

    // Forced grant: CPU loads every cycle, grant after MAX_WAIT cycles.
    n0 = cyc;
    dma_access("forced", 1'b0, 32'h20, 32'h0, 1, 20, a0);
    check32("forced_latency", 32'(a0 - n0), 32'(MAX_WAIT));
    dma_req = 1'b0;
    tick(ga, gs);               // stalled load is performed here
    check1("forced_no_restall", gs, 1'b0);
    cpu_rd = 1'b0;
    tick(ga, gs);

    // Back-to-back: held request, idle CPU -> acks two cycles apart.
    n0 = cyc;
    dma_access("b2b0", 1'b1, 32'h30, 32'hB0B0_0000, 0, 20, a0);
    dma_access("b2b1", 1'b1, 32'h31, 32'hB0B0_0001, 0, 20, a1);
    dma_access("b2b2", 1'b1, 32'h32, 32'hB0B0_0002, 0, 20, a2);
    check32("b2b_ack0", 32'(a0 - n0), 32'd1);
    check32("b2b_ack1", 32'(a1 - n0), 32'd3);
    check32("b2b_ack2", 32'(a2 - n0), 32'd5);
    dma_req = 1'b0;
    tick(ga, gs);

    // Rejected write into peripheral space leaves the LED register alone.
    led_before = led;
    dma_access("reject", 1'b1, 32'h4000_000C, 32'hDEAD_BEEF, 0, 20, a0);
    dma_req = 1'b0;
    tick(ga, gs);
    check32("reject_led", led, led_before);

    // Reset while the DMA master owns the port.
    dma_req  = 1'b1;
    dma_we   = 1'b0;
    dma_addr = 32'h21;
    tick(ga, gs);               // grant decided; now in the DMA cycle
    mon_en = 1'b0;
    exp_cyc.delete();
    exp_load.delete();
    cpu_rd   = 1'b1;
    cpu_addr = 32'h18;
    #1;
    check1("rst_mid_pre_ack", dma_ack, 1'b1);
    check1("rst_mid_pre_stall", cpu_stall, 1'b1);
    reset_b = 1'b0;
    #1;
    check1("rst_mid_ack", dma_ack, 1'b0);
    check1("rst_mid_stall", cpu_stall, 1'b0);
    check1("rst_mid_mem_rd", mem_rd, 1'b1);
    check32("rst_mid_mem_addr", mem_addr, 32'h18);
    check32("rst_mid_dma_rdata", dma_rdata, 32'h0);
    dma_req = 1'b0;
    cpu_rd  = 1'b0;
    @(posedge clk);
    #1;
    reset_b = 1'b1;
    model_reset();

    // MAX_WAIT=1 with a CPU that never idles: grant every other cycle.
    cpu_rd1    = 1'b1;
    cpu_addr1  = 32'h4;
    cpu_wdata1 = 32'h77;
    dma_req1   = 1'b1;
    dma_we1    = 1'b0;
    dma_addr1  = 32'h8;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      want = ((k % 2) == 1);
      check1("w1_ack", dma_ack1, want);
      check1("w1_stall", cpu_stall1, want);
      check1("w1_mem_wr", mem_wr1, 1'b0);
      check32("w1_mem_wdata", mem_wdata1, want ? 32'h0 : 32'h77);
      if (want) check1("w1_err", dma_err1, 1'b0);
      else      check32("w1_cpu_rdata", cpu_rdata1, 32'h4 ^ K1);
      @(posedge clk);
      #1;
    end
    dma_req1 = 1'b0;
    cpu_rd1  = 1'b0;
    @(negedge clk);
    check32("w1_dma_rdata", dma_rdata1, 32'h8 ^ K1);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Randomised traffic: a mostly idle CPU, then a mostly busy one.
    hold_cpu = 1'b0;
    for (int phase = 0; phase < 2; phase++) begin
      idle_pct = (phase == 0) ? 40 : 5;
      for (int n = 0; n < 1500; n++) begin
        if (!hold_cpu) begin
          r         = int'($urandom_range(0, 99));
          cpu_rd    = (r >= idle_pct) && (r < idle_pct + (100 - idle_pct) / 2);
          cpu_wr    = (r >= idle_pct + (100 - idle_pct) / 2);
          cpu_addr  = 32'($urandom_range(0, 63));
          cpu_wdata = $urandom();
        end
        if (!dma_req && $urandom_range(0, 2) == 0) begin
          dma_req   = 1'b1;
          dma_we    = 1'($urandom_range(0, 1));
          r         = int'($urandom_range(0, 9));
          dma_addr  = (r == 0) ? LIMIT + 32'($urandom_range(0, 15) * 4) :
                      (r == 1) ? LIMIT - 32'd1 :
                      (r == 2) ? LIMIT :
                                 32'($urandom_range(0, 63));
          dma_wdata = $urandom();
        end
        tick(ga, gs);
        hold_cpu = gs;
        if (ga) dma_req = 1'b0;
      end
    end

    // Drain.
    dma_req = 1'b0;
    cpu_rd  = 1'b0;
    cpu_wr  = 1'b0;
    repeat (3) tick(ga, gs);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
